// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   Groups the request, split and grant signals shared between the bus
//   masters / slave-split logic and the two-master bus arbiter.
//
//   Signals
//     m1_request        master 1 wants the bus (held for the whole transaction)
//     m2_request        master 2 wants the bus
//     slave_split       1-cycle pulse: addressed slave splits the transaction
//     slave_split_done  1-cycle pulse: split slave is ready to complete
//     m1_grant          master 1 owns the bus
//     m2_grant          master 2 owns the bus
//     bus_busy          either grant is high
//     bus_owner         0 none, 1 master 1, 2 master 2
//     split_pending     a split transaction is outstanding
//     timeout_evt       1-cycle pulse when a grant is revoked by timeout
//
//   Modports
//     master  the requesting side (masters plus slave split signalling):
//             drives requests and split pulses, observes grants/status
//     slave   the arbiter itself: observes requests, drives grants/status
// ---------------------------------------------------------------------------
interface bus_arbiter_if;
    logic       m1_request;
    logic       m2_request;
    logic       slave_split;
    logic       slave_split_done;
    logic       m1_grant;
    logic       m2_grant;
    logic       bus_busy;
    logic [1:0] bus_owner;
    logic       split_pending;
    logic       timeout_evt;

    modport master (
        output m1_request,
        output m2_request,
        output slave_split,
        output slave_split_done,
        input  m1_grant,
        input  m2_grant,
        input  bus_busy,
        input  bus_owner,
        input  split_pending,
        input  timeout_evt
    );

    modport slave (
        input  m1_request,
        input  m2_request,
        input  slave_split,
        input  slave_split_done,
        output m1_grant,
        output m2_grant,
        output bus_busy,
        output bus_owner,
        output split_pending,
        output timeout_evt
    );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master arbiter for the shared serial bus. Grants one master at a time
//   with round-robin tie-break, revokes a grant after TIMEOUT cycles when the
//   other eligible master is waiting, and parks a master whose transaction
//   was split by the slave until the slave reports split completion.
//
//   Parameters
//     TIMEOUT  max grant cycles for the owner while the other eligible master
//              is requesting (>= 2)
//     CNT_W    hold-counter width, must be able to hold TIMEOUT-1
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    bus_arbiter_if.slave: requests / split pulses in,
//            grants, bus_busy, bus_owner, split_pending, timeout_evt out
//
//   All outputs come straight from flops. There is always at least one IDLE
//   cycle between two owners (bus turnaround).
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    // Master identifiers are kept as one bit internally: 0 = m1, 1 = m2.
    state_t           state_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             last_owner_reg;
    logic             split_pending_reg;
    logic             split_master_reg;
    logic             split_return_reg;    // pending split was cleared last cycle
    logic             return_master_reg;   // master whose split was cleared
    logic             m1_grant_reg;
    logic             m2_grant_reg;
    logic             bus_busy_reg;
    logic [1:0]       bus_owner_reg;
    logic             timeout_evt_reg;

    // -----------------------------------------------------------------------
    // Eligibility: a master parked by an outstanding split is not eligible.
    // -----------------------------------------------------------------------
    logic m1_elig;
    logic m2_elig;

    assign m1_elig = bus.m1_request & ~(split_pending_reg & ~split_master_reg);
    assign m2_elig = bus.m2_request & ~(split_pending_reg &  split_master_reg);

    // -----------------------------------------------------------------------
    // IDLE arbitration. A master returning from a split (pending cleared this
    // or the previous cycle) beats round-robin when it is eligible; otherwise
    // the master that did not own the bus last wins a tie.
    // -----------------------------------------------------------------------
    logic done_clears;
    logic ret_valid;
    logic ret_master;
    logic ret_elig;
    logic pick_m2;
    logic grant_m1;
    logic grant_m2;

    assign done_clears = bus.slave_split_done & split_pending_reg;
    assign ret_valid   = split_return_reg | done_clears;
    assign ret_master  = split_return_reg ? return_master_reg : split_master_reg;
    assign ret_elig    = ret_master ? m2_elig : m1_elig;
    assign pick_m2     = (ret_valid & ret_elig) ? ret_master : ~last_owner_reg;
    assign grant_m1    = m1_elig & (~m2_elig | ~pick_m2);
    assign grant_m2    = m2_elig & ~grant_m1;

    // -----------------------------------------------------------------------
    // Owner-side exit conditions while in GNT1/GNT2.
    // A split is accepted only when none is outstanding, or when the
    // outstanding one completes in the same cycle (one split in flight max).
    // -----------------------------------------------------------------------
    logic in_grant;
    logic owner_is_m2;
    logic own_req;
    logic other_elig;
    logic split_accept;
    logic at_limit;
    logic grant_end;
    logic timed_out;

    assign in_grant     = (state_reg == GNT1) | (state_reg == GNT2);
    assign owner_is_m2  = (state_reg == GNT2);
    assign own_req      = owner_is_m2 ? bus.m2_request : bus.m1_request;
    assign other_elig   = owner_is_m2 ? m1_elig : m2_elig;
    assign split_accept = bus.slave_split & (~split_pending_reg | bus.slave_split_done);
    assign at_limit     = (hold_cnt_reg == CNT_MAX);
    // Exit priority: split, then request drop, then timeout.
    assign grant_end    = split_accept | ~own_req | (at_limit & other_elig);
    assign timed_out    = ~split_accept & own_req & at_limit & other_elig;

    // -----------------------------------------------------------------------
    // FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            hold_cnt_reg      <= '0;
            last_owner_reg    <= 1'b1;     // m2 "owned last" so m1 wins the first tie
            split_pending_reg <= 1'b0;
            split_master_reg  <= 1'b0;
            split_return_reg  <= 1'b0;
            return_master_reg <= 1'b0;
            m1_grant_reg      <= 1'b0;
            m2_grant_reg      <= 1'b0;
            bus_busy_reg      <= 1'b0;
            bus_owner_reg     <= 2'd0;
            timeout_evt_reg   <= 1'b0;
        end else begin
            timeout_evt_reg   <= 1'b0;
            split_return_reg  <= done_clears;
            return_master_reg <= split_master_reg;

            // Split bookkeeping. A new split recorded in the same cycle as a
            // completion keeps pending set and retargets it to the new master.
            if (in_grant && split_accept) begin
                split_pending_reg <= 1'b1;
                split_master_reg  <= owner_is_m2;
            end else if (done_clears) begin
                split_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= '0;
                    if (grant_m1) begin
                        state_reg      <= GNT1;
                        last_owner_reg <= 1'b0;
                        m1_grant_reg   <= 1'b1;
                        m2_grant_reg   <= 1'b0;
                        bus_busy_reg   <= 1'b1;
                        bus_owner_reg  <= 2'd1;
                    end else if (grant_m2) begin
                        state_reg      <= GNT2;
                        last_owner_reg <= 1'b1;
                        m1_grant_reg   <= 1'b0;
                        m2_grant_reg   <= 1'b1;
                        bus_busy_reg   <= 1'b1;
                        bus_owner_reg  <= 2'd2;
                    end else begin
                        state_reg      <= IDLE;
                        m1_grant_reg   <= 1'b0;
                        m2_grant_reg   <= 1'b0;
                        bus_busy_reg   <= 1'b0;
                        bus_owner_reg  <= 2'd0;
                    end
                end

                GNT1, GNT2: begin
                    if (grant_end) begin
                        state_reg       <= IDLE;
                        hold_cnt_reg    <= '0;
                        m1_grant_reg    <= 1'b0;
                        m2_grant_reg    <= 1'b0;
                        bus_busy_reg    <= 1'b0;
                        bus_owner_reg   <= 2'd0;
                        timeout_evt_reg <= timed_out;
                    end else if (!at_limit) begin
                        // Saturates at TIMEOUT-1 so a lone owner never wraps
                        // and times out the moment the other master shows up.
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    hold_cnt_reg  <= '0;
                    m1_grant_reg  <= 1'b0;
                    m2_grant_reg  <= 1'b0;
                    bus_busy_reg  <= 1'b0;
                    bus_owner_reg <= 2'd0;
                end
            endcase
        end
    end

    assign bus.m1_grant      = m1_grant_reg;
    assign bus.m2_grant      = m2_grant_reg;
    assign bus.bus_busy      = bus_busy_reg;
    assign bus.bus_owner     = bus_owner_reg;
    assign bus.split_pending = split_pending_reg;
    assign bus.timeout_evt   = timeout_evt_reg;

endmodule
